// File: rtl/board_power_sequencer_pkg.sv
// Shared state encoding and LED patterns for the board power sequencer.
package board_power_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_WAIT_PG = 3'd1,
    ST_LATCH   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam logic [3:0] LED_OFF     = 4'b0000;
  localparam logic [3:0] LED_HOLD    = 4'b0001;
  localparam logic [3:0] LED_WAIT_PG = 4'b0010;
  localparam logic [3:0] LED_RELEASE = 4'b0100;
  localparam logic [3:0] LED_FAULT   = 4'b1111;

  // RUN shows the low strap bits so the board variant is visible at a glance.
  function automatic logic [3:0] led_pattern(state_t st, logic blink, logic [2:0] id_lo);
    logic [3:0] p;
    p = LED_OFF;
    case (st)
      ST_HOLD:              p = LED_HOLD;
      ST_WAIT_PG:           p = blink ? LED_WAIT_PG : LED_OFF;
      ST_LATCH, ST_RELEASE: p = LED_RELEASE;
      ST_RUN:               p = {1'b0, id_lo};
      ST_FAULT:             p = blink ? LED_FAULT : LED_OFF;
      default:              p = LED_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/board_power_sequencer_if.sv
// Board pin bundle: raw inputs from the board, sequenced outputs to fabric and LEDs.
interface board_power_sequencer_if;
  logic       button_aresetn;
  logic       power_good;
  logic [4:0] board_id;
  logic       seq_aresetn;
  logic [4:0] board_id_latched;
  logic       board_id_valid;
  logic [3:0] led;
  logic       led_done;
  logic       fault;

  modport master (
    input  button_aresetn, power_good, board_id,
    output seq_aresetn, board_id_latched, board_id_valid, led, led_done, fault
  );

  modport slave (
    output button_aresetn, power_good, board_id,
    input  seq_aresetn, board_id_latched, board_id_valid, led, led_done, fault
  );
endinterface

// File: rtl/board_power_sequencer_sync_debounce.sv
// Multi-flop synchroniser followed by a debounce filter; output resets to 0 (pressed).
module board_power_sequencer_sync_debounce #(
  parameter int STAGES = 2,
  parameter int CYCLES = 1_000_000
) (
  input  logic aclk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [STAGES-1:0] sync_q;
  logic [CW-1:0]     cnt_q;
  logic              sample;

  assign sample = sync_q[STAGES-1];

  // Any sample that agrees with the accepted level restarts the run.
  always_ff @(posedge aclk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout   <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(din);
      if (sample == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        dout  <= sample;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/board_power_sequencer.sv
// Board bring-up: button debounce, power-good qualification, strap latch,
// fabric reset release, status LEDs and fault trapping.
module board_power_sequencer
  import board_power_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int PG_STABLE_CYCLES  = 10_000_000,
  parameter int PG_TIMEOUT_CYCLES = 500_000_000,
  parameter int RELEASE_DELAY     = 16,
  parameter int BLINK_CYCLES      = 25_000_000
) (
  input logic aclk,
  input logic reset,
  board_power_sequencer_if.master bus
);
  localparam int SW = $clog2(PG_STABLE_CYCLES + 1);
  localparam int TW = $clog2(PG_TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_DELAY + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  logic          btn_db;
  logic          pg_s1, pg_sync;
  logic [4:0]    id_s1, id_sync;

  state_t        state_q;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] rel_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink;

  logic          seq_q, done_q, fault_q, valid_q;
  logic [4:0]    id_q;
  logic [3:0]    led_q;

  board_power_sequencer_sync_debounce #(
    .STAGES (2),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .aclk  (aclk),
    .reset (reset),
    .din   (bus.button_aresetn),
    .dout  (btn_db)
  );

  // Straps are only sampled once they have been static for many cycles, so a
  // per-bit synchroniser without bus coherency handling is sufficient.
  always_ff @(posedge aclk) begin
    if (reset) begin
      pg_s1   <= 1'b0;
      pg_sync <= 1'b0;
      id_s1   <= '0;
      id_sync <= '0;
    end else begin
      pg_s1   <= bus.power_good;
      pg_sync <= pg_s1;
      id_s1   <= bus.board_id;
      id_sync <= id_s1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      stable_cnt <= '0;
      to_cnt     <= '0;
      rel_cnt    <= '0;
      seq_q      <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      valid_q    <= 1'b0;
      id_q       <= '0;
    end else if (!btn_db) begin
      state_q    <= ST_HOLD;
      stable_cnt <= '0;
      to_cnt     <= '0;
      rel_cnt    <= '0;
      seq_q      <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          state_q    <= ST_WAIT_PG;
          stable_cnt <= '0;
          to_cnt     <= '0;
          rel_cnt    <= '0;
          valid_q    <= 1'b0;
        end
        // A glitch restarts the stability window but not the overall timeout.
        ST_WAIT_PG: begin
          to_cnt     <= (to_cnt == TW'(PG_TIMEOUT_CYCLES)) ? to_cnt : to_cnt + 1'b1;
          stable_cnt <= !pg_sync ? '0 :
                        (stable_cnt == SW'(PG_STABLE_CYCLES)) ? stable_cnt : stable_cnt + 1'b1;
          if (pg_sync && stable_cnt == SW'(PG_STABLE_CYCLES - 1)) begin
            state_q <= ST_LATCH;
          end else if (to_cnt == TW'(PG_TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end
        end
        ST_LATCH: begin
          id_q    <= id_sync;
          valid_q <= 1'b1;
          rel_cnt <= '0;
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!pg_sync) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else if (rel_cnt == RW'(RELEASE_DELAY - 1)) begin
            state_q <= ST_RUN;
            seq_q   <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            rel_cnt <= (rel_cnt == RW'(RELEASE_DELAY)) ? rel_cnt : rel_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!pg_sync) begin
            state_q <= ST_FAULT;
            seq_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b1;
          end
        end
        ST_FAULT: begin
          seq_q   <= 1'b0;
          done_q  <= 1'b0;
          fault_q <= 1'b1;
        end
        default: state_q <= ST_HOLD;
      endcase
    end
  end

  // LEDs follow the registered state, so they lag a state change by one cycle.
  always_ff @(posedge aclk) begin
    if (reset) begin
      led_q <= LED_OFF;
    end else begin
      led_q <= led_pattern(state_q, blink, id_q[2:0]);
    end
  end

  assign bus.seq_aresetn      = seq_q;
  assign bus.board_id_latched = id_q;
  assign bus.board_id_valid   = valid_q;
  assign bus.led              = led_q;
  assign bus.led_done         = done_q;
  assign bus.fault            = fault_q;
endmodule

// File: tb/tb_board_power_sequencer.sv
// Directed scenarios plus a random soak, checked every cycle against an event-time model.
module tb_board_power_sequencer;
  localparam int DEBOUNCE = 4;
  localparam int PG_STABLE = 8;
  localparam int PG_TIMEOUT = 40;
  localparam int RELEASE = 3;
  localparam int BLINK = 2;

  localparam int M_HOLD = 0, M_WAIT = 1, M_LATCH = 2, M_REL = 3, M_RUN = 4, M_FAULT = 5;

  logic aclk;
  logic reset;
  board_power_sequencer_if bus ();

  board_power_sequencer #(
    .DEBOUNCE_CYCLES   (DEBOUNCE),
    .PG_STABLE_CYCLES  (PG_STABLE),
    .PG_TIMEOUT_CYCLES (PG_TIMEOUT),
    .RELEASE_DELAY     (RELEASE),
    .BLINK_CYCLES      (BLINK)
  ) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: phases with entry timestamps; counters are replaced by "edges since" arithmetic.
  int         m_phase = M_HOLD;
  int         m_start = 0;
  int         m_last_low = 0;
  int         m_last_match = 0;
  int         m_rst_edge = 0;
  bit         m_db = 0;
  bit         m_b1 = 0, m_b2 = 0, m_p1 = 0, m_p2 = 0;
  logic [4:0] m_i1 = '0, m_i2 = '0;
  bit         m_valid = 0;
  logic [4:0] m_latched = '0;
  logic [3:0] m_led = '0;

  function automatic logic [3:0] led_expect(int ph, int blink_on, logic [4:0] id);
    if (ph == M_HOLD) return 4'b0001;
    if (ph == M_WAIT) return (blink_on != 0) ? 4'b0010 : 4'b0000;
    if (ph == M_LATCH || ph == M_REL) return 4'b0100;
    if (ph == M_RUN) return {1'b0, id[2:0]};
    return (blink_on != 0) ? 4'b1111 : 4'b0000;
  endfunction

  task automatic model_edge();
    bit bs, ps;
    logic [4:0] is_;
    logic [3:0] led_next;
    int run_from;
    cyc++;
    if (reset) begin
      m_phase = M_HOLD; m_db = 0; m_valid = 0; m_latched = '0; m_led = '0;
      m_last_match = cyc; m_last_low = cyc; m_rst_edge = cyc; m_start = cyc;
      m_b1 = 0; m_b2 = 0; m_p1 = 0; m_p2 = 0; m_i1 = '0; m_i2 = '0;
      return;
    end
    bs = m_b2; ps = m_p2; is_ = m_i2;
    led_next = led_expect(m_phase, ((cyc - 1 - m_rst_edge) / BLINK) % 2, m_latched);
    if (!ps) m_last_low = cyc;
    run_from = (m_last_low > m_start) ? m_last_low : m_start;
    if (!m_db) begin
      m_phase = M_HOLD;
      m_valid = 0;
    end else begin
      case (m_phase)
        M_HOLD: begin m_phase = M_WAIT; m_start = cyc; end
        M_WAIT: begin
          if (ps && (cyc - run_from) == PG_STABLE) m_phase = M_LATCH;
          else if ((cyc - m_start) == PG_TIMEOUT) m_phase = M_FAULT;
        end
        M_LATCH: begin m_latched = is_; m_valid = 1; m_phase = M_REL; m_start = cyc; end
        M_REL: begin
          if (!ps) m_phase = M_FAULT;
          else if ((cyc - m_start) == RELEASE) m_phase = M_RUN;
        end
        M_RUN: if (!ps) m_phase = M_FAULT;
        default: ;
      endcase
    end
    if (bs == m_db) m_last_match = cyc;
    else if ((cyc - m_last_match) == DEBOUNCE) begin m_db = bs; m_last_match = cyc; end
    m_b2 = m_b1; m_b1 = bus.button_aresetn;
    m_p2 = m_p1; m_p1 = bus.power_good;
    m_i2 = m_i1; m_i1 = bus.board_id;
    m_led = led_next;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("seq_aresetn", 8'(bus.seq_aresetn), 8'(m_phase == M_RUN));
    check("led_done", 8'(bus.led_done), 8'(m_phase == M_RUN));
    check("fault", 8'(bus.fault), 8'(m_phase == M_FAULT));
    check("board_id_valid", 8'(bus.board_id_valid), 8'(m_valid));
    check("board_id_latched", 8'(bus.board_id_latched), 8'(m_latched));
    check("led", 8'(bus.led), 8'(m_led));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge aclk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic press_button(input int n);
    bus.button_aresetn = 1'b0;
    step(n);
  endtask

  logic [4:0] id_r;

  initial begin
    reset = 1'b1;
    bus.button_aresetn = 1'b0;
    bus.power_good = 1'b0;
    bus.board_id = '0;
    step(3);
    check("rst_seq_aresetn", 8'(bus.seq_aresetn), 8'h00);
    check("rst_led", 8'(bus.led), 8'h00);

    // Normal bring-up.
    reset = 1'b0;
    bus.button_aresetn = 1'b1;
    bus.power_good = 1'b1;
    bus.board_id = 5'h13;
    step(30);
    check("norm_latched", 8'(bus.board_id_latched), 8'h13);
    check("norm_valid", 8'(bus.board_id_valid), 8'h01);
    check("norm_seq", 8'(bus.seq_aresetn), 8'h01);
    check("norm_led", 8'(bus.led), 8'h03);
    check("norm_done", 8'(bus.led_done), 8'h01);

    // Button bounce while held in HOLD.
    press_button(10);
    for (int b = 0; b < 3; b++) begin
      bus.button_aresetn = 1'b1; step(2);
      bus.button_aresetn = 1'b0; step(2);
    end
    step(6);
    check("bounce_seq", 8'(bus.seq_aresetn), 8'h00);
    check("bounce_led", 8'(bus.led), 8'h01);

    // Power-good glitch during WAIT_PG.
    id_r = 5'($urandom);
    bus.board_id = id_r;
    bus.power_good = 1'b0;
    bus.button_aresetn = 1'b1;
    step(9);
    bus.power_good = 1'b1; step(6);
    bus.power_good = 1'b0; step(1);
    bus.power_good = 1'b1; step(25);
    check("glitch_latched", 8'(bus.board_id_latched), 8'(id_r));
    check("glitch_seq", 8'(bus.seq_aresetn), 8'h01);

    // Power-good timeout.
    press_button(8);
    bus.power_good = 1'b0;
    bus.button_aresetn = 1'b1;
    step(60);
    check("timeout_fault", 8'(bus.fault), 8'h01);
    check("timeout_seq", 8'(bus.seq_aresetn), 8'h00);

    // Power loss in RUN, then recovery by button.
    press_button(8);
    check("recover_fault_clear", 8'(bus.fault), 8'h00);
    bus.power_good = 1'b1;
    bus.button_aresetn = 1'b1;
    step(30);
    check("run_seq", 8'(bus.seq_aresetn), 8'h01);
    bus.power_good = 1'b0;
    step(3);
    check("loss_seq", 8'(bus.seq_aresetn), 8'h00);
    check("loss_fault", 8'(bus.fault), 8'h01);
    press_button(8);
    check("loss_hold_led", 8'(bus.led), 8'h01);
    bus.button_aresetn = 1'b1;
    step(10);

    // Reset during RELEASE.
    press_button(8);
    bus.power_good = 1'b1;
    bus.button_aresetn = 1'b1;
    for (int k = 0; k < 100 && bus.board_id_valid !== 1'b1; k++) step(1);
    check("reach_release", 8'(bus.board_id_valid), 8'h01);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_valid", 8'(bus.board_id_valid), 8'h00);
    check("midrst_latched", 8'(bus.board_id_latched), 8'h00);
    check("midrst_led", 8'(bus.led), 8'h00);
    step(30);
    check("midrst_rerun", 8'(bus.seq_aresetn), 8'h01);

    // Random soak.
    for (int s = 0; s < 200; s++) begin
      bus.button_aresetn = ($urandom_range(0, 7) != 0);
      bus.power_good = ($urandom_range(0, 5) != 0);
      bus.board_id = 5'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      step($urandom_range(1, 24));
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
